// File: rtl/sdr_cmd_seq.sv
// rtl/sdr_cmd_seq.sv - SDRAM command sequencer: one request in flight, per-bank row tracking.
// Optional periodic refresh is built when SDR_AUTO_REFRESH_EN is defined.
module sdr_cmd_seq #(
  parameter int BURST_LENGTH = 1,
  parameter int TRAS         = 1,
  parameter int TRCD         = 1,
  parameter int TRP          = 1,
  parameter int TRFC         = 4,
  parameter int TREFI        = 1560,
  parameter int ROW_W        = 13,
  parameter int COL_W        = 9
) (
  input  logic             sdram_clk,
  input  logic             sdram_resetn,
  input  logic             sdr_init_done,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic             req_ap,
  input  logic [1:0]       req_bank,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             xfr_start,
  output logic             ref_busy,
  output logic             sdr_cke,
  output logic             sdr_cs_n,
  output logic             sdr_ras_n,
  output logic             sdr_cas_n,
  output logic             sdr_we_n,
  output logic [1:0]       sdr_ba,
  output logic [12:0]      sdr_addr
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_PRE, S_ACT, S_CAS, S_WAIT, S_RPRE, S_RWAIT, S_RREF
  } state_t;

  state_t           state, state_n, ret_state, ret_n, wait_tgt;
  logic [8:0]       wait_cnt, wait_n, wait_len;
  logic [3:0]       cmd_q, cmd_n;
  logic [1:0]       ba_q, ba_n;
  logic [12:0]      addr_q, addr_n;
  logic             cke_q, ready_q, xfr_q, xfr_n, ref_busy_q;
  logic [3:0]       bank_open, clr_open;
  logic [ROW_W-1:0] row_tab [4];
  logic [7:0]       tras_tmr [4];
  logic             l_wr, l_ap;
  logic [1:0]       l_bank;
  logic [ROW_W-1:0] l_row;
  logic [COL_W-1:0] l_col;
  logic             cur_wr, cur_ap;
  logic [1:0]       cur_bank;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             latch, issue_act, issue_cas, set_open, ref_done, start_wait, wait_ref;
  logic             ref_pend, ref_pend_n;
  logic             req_hit;
  logic [1:0]       low_bank;

  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
  assign sdr_ba    = ba_q;
  assign sdr_addr  = addr_q;
  assign sdr_cke   = cke_q;
  assign req_ready = ready_q;
  assign xfr_start = xfr_q;

  // The first command of a request is issued straight from the accept cycle, so fields come from the inputs there.
  always_comb begin
    if (state == S_IDLE) begin
      cur_wr = req_wr; cur_ap = req_ap; cur_bank = req_bank; cur_row = req_row; cur_col = req_col;
    end else begin
      cur_wr = l_wr; cur_ap = l_ap; cur_bank = l_bank; cur_row = l_row; cur_col = l_col;
    end
  end

  assign req_hit = bank_open[req_bank] && (row_tab[req_bank] == req_row);

  always_comb begin
    low_bank = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bank_open[i]) low_bank = 2'(i);
    end
  end

  always_comb begin
    state_n    = state;
    ret_n      = ret_state;
    wait_n     = wait_cnt;
    cmd_n      = CMD_NOP;
    ba_n       = ba_q;
    addr_n     = addr_q;
    xfr_n      = 1'b0;
    clr_open   = 4'b0000;
    set_open   = 1'b0;
    latch      = 1'b0;
    issue_act  = 1'b0;
    issue_cas  = 1'b0;
    ref_done   = 1'b0;
    start_wait = 1'b0;
    wait_len   = 9'd0;
    wait_tgt   = S_IDLE;
    wait_ref   = 1'b0;
    case (state)
      S_INIT: if (sdr_init_done) state_n = S_IDLE;
      S_IDLE: begin
        if (ref_pend) begin
          state_n = S_RPRE;
        end else if (req_valid && ready_q) begin
          latch = 1'b1;
          if (req_hit)                 issue_cas = 1'b1;
          else if (bank_open[req_bank]) state_n  = S_PRE;
          else                         issue_act = 1'b1;
        end
      end
      S_PRE: begin
        if (tras_tmr[l_bank] == 8'd0) begin
          cmd_n            = CMD_PRE;
          ba_n             = l_bank;
          addr_n           = 13'd0;
          clr_open[l_bank] = 1'b1;
          start_wait       = 1'b1;
          wait_len         = 9'(TRP);
          wait_tgt         = S_ACT;
        end
      end
      S_ACT: issue_act = 1'b1;
      S_CAS: issue_cas = 1'b1;
      S_WAIT, S_RWAIT: begin
        if (wait_cnt <= 9'd1) state_n = ret_state;
        else                  wait_n  = wait_cnt - 9'd1;
      end
      // Close open banks one per cycle in ascending order; TRP runs from the last one.
      S_RPRE: begin
        if (bank_open != 4'b0000) begin
          if (tras_tmr[low_bank] == 8'd0) begin
            cmd_n              = CMD_PRE;
            ba_n               = low_bank;
            addr_n             = 13'd0;
            clr_open[low_bank] = 1'b1;
            if ((bank_open & ~(4'b0001 << low_bank)) == 4'b0000) begin
              start_wait = 1'b1;
              wait_len   = 9'(TRP);
              wait_tgt   = S_RREF;
              wait_ref   = 1'b1;
            end
          end
        end else begin
          state_n = S_RREF;
        end
      end
      S_RREF: begin
        cmd_n      = CMD_REF;
        ba_n       = 2'd0;
        addr_n     = 13'd0;
        ref_done   = 1'b1;
        start_wait = 1'b1;
        wait_len   = 9'(TRFC);
        wait_tgt   = S_IDLE;
        wait_ref   = 1'b1;
      end
      default: state_n = S_INIT;
    endcase

    if (issue_act) begin
      cmd_n      = CMD_ACT;
      ba_n       = cur_bank;
      addr_n     = 13'(cur_row);
      set_open   = 1'b1;
      start_wait = 1'b1;
      wait_len   = 9'(TRCD);
      wait_tgt   = S_CAS;
    end

    if (issue_cas) begin
      cmd_n              = cur_wr ? CMD_WR : CMD_RD;
      ba_n               = cur_bank;
      addr_n             = 13'd0;
      addr_n[COL_W-1:0]  = cur_col;
      addr_n[10]         = cur_ap;
      xfr_n              = 1'b1;
      clr_open[cur_bank] = cur_ap;
      start_wait         = 1'b1;
      wait_len           = cur_ap ? 9'(BURST_LENGTH + TRP) : 9'(BURST_LENGTH);
      wait_tgt           = S_IDLE;
    end

    // A delay of N means N-1 wait cycles before the target state issues its command.
    if (start_wait) begin
      if (wait_len <= 9'd1) begin
        state_n = wait_tgt;
      end else begin
        state_n = wait_ref ? S_RWAIT : S_WAIT;
        ret_n   = wait_tgt;
        wait_n  = wait_len - 9'd1;
      end
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state      <= S_INIT;
      ret_state  <= S_IDLE;
      wait_cnt   <= 9'd0;
      cmd_q      <= CMD_NOP;
      ba_q       <= 2'd0;
      addr_q     <= 13'd0;
      cke_q      <= 1'b0;
      ready_q    <= 1'b0;
      xfr_q      <= 1'b0;
      ref_busy_q <= 1'b0;
      bank_open  <= 4'b0000;
      l_wr       <= 1'b0;
      l_ap       <= 1'b0;
      l_bank     <= 2'd0;
      l_row      <= '0;
      l_col      <= '0;
      for (int i = 0; i < 4; i++) begin
        row_tab[i]  <= '0;
        tras_tmr[i] <= 8'd0;
      end
    end else begin
      state      <= state_n;
      ret_state  <= ret_n;
      wait_cnt   <= wait_n;
      cmd_q      <= cmd_n;
      ba_q       <= ba_n;
      addr_q     <= addr_n;
      cke_q      <= 1'b1;
      ready_q    <= (state_n == S_IDLE) && !ref_pend_n;
      xfr_q      <= xfr_n;
      ref_busy_q <= (state_n == S_RPRE) || (state_n == S_RWAIT) || (state_n == S_RREF);
      if (latch) begin
        l_wr   <= req_wr;
        l_ap   <= req_ap;
        l_bank <= req_bank;
        l_row  <= req_row;
        l_col  <= req_col;
      end
      for (int i = 0; i < 4; i++) begin
        if (set_open && (cur_bank == 2'(i))) begin
          bank_open[i] <= 1'b1;
          row_tab[i]   <= cur_row;
          tras_tmr[i]  <= 8'(TRAS - 1);
        end else begin
          if (clr_open[i]) bank_open[i] <= 1'b0;
          if (tras_tmr[i] != 8'd0) tras_tmr[i] <= tras_tmr[i] - 8'd1;
        end
      end
    end
  end

`ifdef SDR_AUTO_REFRESH_EN
  logic [15:0] refi_cnt;

  // An expiry while already pending is absorbed: the counter parks at zero until the next REF.
  assign ref_pend_n = !ref_done && (ref_pend || (refi_cnt == 16'd0));
  assign ref_busy   = ref_busy_q;

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      refi_cnt <= 16'd0;
      ref_pend <= 1'b0;
    end else begin
      ref_pend <= ref_pend_n;
      if (ref_done)                refi_cnt <= 16'(TREFI - 1);
      else if (refi_cnt != 16'd0)  refi_cnt <= refi_cnt - 16'd1;
    end
  end
`else
  logic unused_ref;
  assign ref_pend   = 1'b0;
  assign ref_pend_n = 1'b0;
  assign ref_busy   = 1'b0;
  assign unused_ref = ref_done ^ ref_busy_q ^ (^TREFI);
`endif

endmodule

// File: tb/tb_sdr_cmd_seq.sv
// tb/tb_sdr_cmd_seq.sv - scoreboard bench for sdr_cmd_seq command order, encoding and spacing.
module tb_sdr_cmd_seq;
  localparam int BL    = 4;
  localparam int TRAS  = 10;
  localparam int TRCD  = 2;
  localparam int TRP   = 3;
  localparam int TRFC  = 4;
  localparam int TREFI = 1560;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101;
  localparam logic [3:0] WR = 4'b0100, PRE = 4'b0010, REF = 4'b0001;

  logic        clk = 1'b0;
  logic        resetn, init_done, req_valid, req_ready, req_wr, req_ap;
  logic [1:0]  req_bank;
  logic [12:0] req_row;
  logic [8:0]  req_col;
  logic        xfr_start, ref_busy, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;

  sdr_cmd_seq #(
    .BURST_LENGTH(BL), .TRAS(TRAS), .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC),
    .TREFI(TREFI), .ROW_W(13), .COL_W(9)
  ) dut (
    .sdram_clk(clk), .sdram_resetn(resetn), .sdr_init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_ap(req_ap),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .xfr_start(xfr_start), .ref_busy(ref_busy), .sdr_cke(cke),
    .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
    .sdr_ba(ba), .sdr_addr(addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    int          back;
    int          gap;
    bit          exact;
  } exp_t;

  exp_t sb[$];
  int   cyc_log[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                            input int back, input int gap, input bit exact);
    exp_t e;
    e.cmd = c; e.ba = b; e.addr = a; e.back = back; e.gap = gap; e.exact = exact;
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every non-NOP command pops one expectation; back/gap ties it to an earlier command's cycle.
  always @(negedge clk) begin
    logic [3:0] c;
    exp_t       e;
    int         d;
    c = {cs_n, ras_n, cas_n, we_n};
    if (c != NOP) begin
      if (sb.size() == 0) begin
        check("unexpected_cmd", c, NOP);
      end else begin
        e = sb.pop_front();
        check("cmd", c, e.cmd);
        check("ba", ba, e.ba);
        check("addr", addr, e.addr);
        check("xfr_start", xfr_start, (e.cmd == RD) || (e.cmd == WR));
        if (e.back > 0 && e.back <= cyc_log.size()) begin
          d = cyc - cyc_log[cyc_log.size() - e.back];
          if (e.exact) check("gap", d, e.gap);
          else         check("gap_min_ok", d >= e.gap, 1);
        end
      end
      cyc_log.push_back(cyc);
    end else if (xfr_start) begin
      check("xfr_on_nop", xfr_start, 0);
    end
  end

  task automatic send(input logic wr, input logic ap, input logic [1:0] bank,
                      input logic [12:0] row, input logic [8:0] col);
    int n = 0;
    req_valid = 1'b1; req_wr = wr; req_ap = ap; req_bank = bank; req_row = row; req_col = col;
    while (!req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("accept", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    resetn = 1'b0; init_done = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_ap = 1'b0;
    req_bank = 2'd0; req_row = 13'd0; req_col = 9'd0;
    repeat (3) @(negedge clk);
    check("rst_cke", cke, 0);
    check("rst_cmd", {cs_n, ras_n, cas_n, we_n}, NOP);
    check("rst_ready", req_ready, 0);
    check("rst_ba", ba, 0);
    check("rst_addr", addr, 0);
    check("rst_xfr", xfr_start, 0);
    check("rst_ref_busy", ref_busy, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("cke_on", cke, 1);
    repeat (10) @(negedge clk);
    check("ready_pre_init", req_ready, 0);
`ifdef SDR_AUTO_REFRESH_EN
    expect_cmd(REF, 2'd0, 13'd0, 0, 0, 1'b0);
`endif
    init_done = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("init_ready", req_ready, 1);

    // Closed bank: ACT then RD TRCD later.
    expect_cmd(ACT, 2'd1, 13'h055, 0, 0, 1'b0);
    expect_cmd(RD,  2'd1, 13'h012, 1, TRCD, 1'b1);
    send(1'b0, 1'b0, 2'd1, 13'h055, 9'h012);

    // Back-to-back hits: CAS spacing equals the burst length.
    expect_cmd(WR, 2'd1, 13'h020, 0, 0, 1'b0);
    expect_cmd(RD, 2'd1, 13'h021, 1, BL, 1'b1);
    send(1'b1, 1'b0, 2'd1, 13'h055, 9'h020);
    send(1'b0, 1'b0, 2'd1, 13'h055, 9'h021);

    // Row miss right after opening bank 2: PRE gated by TRAS, ACT TRP after PRE.
    expect_cmd(ACT, 2'd2, 13'h100, 0, 0, 1'b0);
    expect_cmd(RD,  2'd2, 13'h005, 1, TRCD, 1'b1);
    expect_cmd(PRE, 2'd2, 13'h000, 2, TRAS, 1'b0);
    expect_cmd(ACT, 2'd2, 13'h200, 1, TRP, 1'b1);
    expect_cmd(RD,  2'd2, 13'h006, 1, TRCD, 1'b1);
    send(1'b0, 1'b0, 2'd2, 13'h100, 9'h005);
    send(1'b0, 1'b0, 2'd2, 13'h200, 9'h006);

    // Auto-precharge closes the bank: same row needs a new ACT BL+TRP after the RD.
    expect_cmd(RD,  2'd1, 13'h430, 0, 0, 1'b0);
    expect_cmd(ACT, 2'd1, 13'h055, 1, BL + TRP, 1'b1);
    expect_cmd(RD,  2'd1, 13'h031, 1, TRCD, 1'b1);
    send(1'b0, 1'b1, 2'd1, 13'h055, 9'h030);
    send(1'b0, 1'b0, 2'd1, 13'h055, 9'h031);

`ifdef SDR_AUTO_REFRESH_EN
    expect_cmd(ACT, 2'd0, 13'h007, 0, 0, 1'b0);
    expect_cmd(RD,  2'd0, 13'h001, 1, TRCD, 1'b1);
    expect_cmd(ACT, 2'd3, 13'h009, 0, 0, 1'b0);
    expect_cmd(RD,  2'd3, 13'h002, 1, TRCD, 1'b1);
    send(1'b0, 1'b0, 2'd0, 13'h007, 9'h001);
    send(1'b0, 1'b0, 2'd3, 13'h009, 9'h002);
    expect_cmd(PRE, 2'd0, 13'h000, 0, 0, 1'b0);
    expect_cmd(PRE, 2'd1, 13'h000, 1, 1, 1'b1);
    expect_cmd(PRE, 2'd2, 13'h000, 1, 1, 1'b1);
    expect_cmd(PRE, 2'd3, 13'h000, 1, 1, 1'b1);
    expect_cmd(REF, 2'd0, 13'h000, 1, TRP, 1'b1);
    expect_cmd(ACT, 2'd0, 13'h077, 1, TRFC, 1'b1);
    expect_cmd(RD,  2'd0, 13'h004, 1, TRCD, 1'b1);
    n = 0;
    while (!ref_busy && n < 2500) begin
      @(negedge clk);
      n++;
    end
    check("ref_busy", ref_busy, 1);
    check("ready_in_ref", req_ready, 0);
    send(1'b0, 1'b0, 2'd0, 13'h077, 9'h004);
`else
    check("ref_busy_off", ref_busy, 0);
`endif

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
